usb_pd_clk_rst_ctrl: RTL

Clock/reset controller and timebase sitting directly downstream of the USB-PD PLL wrapper. It consumes the PLL's 10 MHz output clock and its lock flag, filters lock, and releases a synchronous system reset only after lock has been stable. It then generates the BMC half-bit/bit strobes (300 kbps nominal) and a 1 ms strobe used by the PD PHY and protocol timers. Loss of lock forces the downstream logic back into reset immediately.

---
 rtl/usb_pd_clk_rst_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/usb_pd_clk_rst_ctrl.sv
`timescale 1ns/1ps
// usb_pd_clk_rst_ctrl
// Clock/reset controller and timebase fed by the USB-PD PLL wrapper.
// Synchronizes and qualifies the PLL lock flag and releases a registered
// active-low system reset once lock has been stable for LOCK_CYCLES cycles.
// While running, it generates BMC half-bit/bit strobes and a 1 ms strobe.
// Losing lock drops the system reset again.
//
// Handshake/strobe semantics: there is no valid/ready handshake here. Every
// *_tick output is a registered single-cycle strobe that is only ever high
// while ready is high.
//
// Ports:
//   clk           in   PLL output clock
//   rst_n         in   async active-low reset, clears every flop
//   pll_lock      in   PLL lock flag, asynchronous to clk
//   sys_rst_n     out  registered active-low reset for downstream logic
//   ready         out  high while in RUN (same flop as sys_rst_n)
//   half_bit_tick out  strobe at HALF_BIT_HZ average rate
//   bit_tick      out  strobe on every second half_bit_tick
//   ms_tick       out  strobe every CLK_HZ/1000 cycles
//   lock_loss_cnt out  saturating count of RUN -> WAIT_LOCK transitions
//   dbg_state_o   out  current FSM state (0 WAIT_LOCK, 1 STABLE, 2 RUN)
module usb_pd_clk_rst_ctrl #(
  parameter int CLK_HZ      = 10_000_000,
  parameter int HALF_BIT_HZ = 600_000,
  parameter int LOCK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       half_bit_tick,
  output logic       bit_tick,
  output logic       ms_tick,
  output logic [7:0] lock_loss_cnt,
  output logic [1:0] dbg_state_o
);

  localparam int ACC_W  = $clog2(CLK_HZ) + 1;
  localparam int MS_N   = CLK_HZ / 1000;
  localparam int MS_W   = $clog2(MS_N + 1);
  localparam int STAB_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [ACC_W-1:0]  HB_C     = ACC_W'(HALF_BIT_HZ);
  localparam logic [ACC_W-1:0]  CLK_C    = ACC_W'(CLK_HZ);
  localparam logic [MS_W-1:0]   MS_MAX   = MS_W'(MS_N - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [7:0]        loss_q, loss_d;
  logic              rdy_q, rdy_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic              parity_q, parity_d;
  logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
  logic              half_q, half_d;
  logic              bit_q, bit_d;
  logic              ms_q, ms_d;
  logic              run_d;
  logic              lock_s;

  assign lock_s = sync2_q;

  // Lock qualification FSM.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    loss_d  = loss_q;
    case (state_q)
      WAIT_LOCK: begin
        stab_d = '0;
        if (lock_s) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          stab_d  = '0;
        end else if (stab_q == STAB_MAX) begin
          state_d = RUN;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + STAB_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Tick registers are loaded from the next state, so the edge entering RUN
  // performs the first accumulation and the edge leaving RUN already yields
  // zero ticks together with the falling sys_rst_n.
  always_comb begin
    run_d    = (state_d == RUN);
    rdy_d    = run_d;
    acc_sum  = acc_q + HB_C;
    acc_d    = '0;
    half_d   = 1'b0;
    parity_d = 1'b0;
    ms_cnt_d = '0;
    if (run_d) begin
      if (acc_sum >= CLK_C) begin
        acc_d  = acc_sum - CLK_C;
        half_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
      parity_d = parity_q ^ half_d;
      // Counter equals the 0-based RUN cycle index modulo MS_N.
      if (state_q == RUN) begin
        ms_cnt_d = (ms_cnt_q == MS_MAX) ? '0 : ms_cnt_q + MS_W'(1);
      end
    end
    bit_d = half_d & parity_q;
    ms_d  = run_d && (ms_cnt_d == MS_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_LOCK;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stab_q   <= '0;
      loss_q   <= '0;
      rdy_q    <= 1'b0;
      acc_q    <= '0;
      parity_q <= 1'b0;
      ms_cnt_q <= '0;
      half_q   <= 1'b0;
      bit_q    <= 1'b0;
      ms_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= pll_lock;
      sync2_q  <= sync1_q;
      stab_q   <= stab_d;
      loss_q   <= loss_d;
      rdy_q    <= rdy_d;
      acc_q    <= acc_d;
      parity_q <= parity_d;
      ms_cnt_q <= ms_cnt_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      ms_q     <= ms_d;
    end
  end

  assign sys_rst_n     = rdy_q;
  assign ready         = rdy_q;
  assign half_bit_tick = half_q;
  assign bit_tick      = bit_q;
  assign ms_tick       = ms_q;
  assign lock_loss_cnt = loss_q;
  assign dbg_state_o   = state_q;

endmodule
